stage_seq_ctrl: RTL and testbench

Multi-pass sequencer for one two-head stage datapath (attention core plus MLP with residual). It accepts one token word at a time over a valid/ready handshake and drives the stage's enable, input and bias pair. It waits for the stage's end flag, captures the stage output and feeds it back as the next input for `N_PASS` passes, so one physical stage instance serves a whole stack of logical stages. It sits between the token stream source and the output buffer; per-pass biases come from a small configurable table.

---
 rtl/stage_seq_ctrl_pkg.sv | 11 +
 rtl/stage_seq_ctrl_bias_table.sv | 39 +++
 rtl/stage_seq_ctrl.sv | 168 ++++++++++++++++
 tb/tb_stage_seq_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stage_seq_ctrl_pkg.sv
// Shared definitions for the multi-pass stage sequencer: datapath word width and FSM states.
package definition;
    localparam int att_width = 16;

    typedef enum logic [1:0] {
        SEQ_IDLE = 2'd0,
        SEQ_RUN  = 2'd1,
        SEQ_GAP  = 2'd2,
        SEQ_OUT  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/stage_seq_ctrl_bias_table.sv
// Per-pass bias pair register file: one write port, one asynchronous read port, cleared on reset.
module stage_bias_table
    import definition::*;
#(
    parameter int N_PASS = 4,
    parameter int AW     = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 we_i,
    input  logic [AW-1:0]        waddr_i,
    input  logic [att_width-1:0] wbias1_i,
    input  logic [att_width-1:0] wbias2_i,
    input  logic [AW-1:0]        raddr_i,
    output logic [att_width-1:0] rbias1_o,
    output logic [att_width-1:0] rbias2_o
);
    logic [att_width-1:0] b1_q [N_PASS];
    logic [att_width-1:0] b2_q [N_PASS];

    // Table storage; out-of-range write addresses are ignored.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < N_PASS; i++) begin
                b1_q[i] <= '0;
                b2_q[i] <= '0;
            end
        end else if (we_i && (32'(waddr_i) < N_PASS)) begin
            b1_q[waddr_i] <= wbias1_i;
            b2_q[waddr_i] <= wbias2_i;
        end else begin
            b1_q <= b1_q;
            b2_q <= b2_q;
        end
    end

    assign rbias1_o = (32'(raddr_i) < N_PASS) ? b1_q[raddr_i] : '0;
    assign rbias2_o = (32'(raddr_i) < N_PASS) ? b2_q[raddr_i] : '0;
endmodule

// File: rtl/stage_seq_ctrl.sv
// Multi-pass sequencer: feeds one token through a single stage instance N_PASS times,
// applying per-pass biases from a configurable table, with a per-pass end-flag timeout.
module stage_seq_ctrl
    import definition::*;
#(
    parameter int N_PASS  = 4,
    parameter int TIMEOUT = 255,
    parameter int PW      = (N_PASS > 1) ? $clog2(N_PASS) : 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [att_width-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [att_width-1:0] out_data,
    input  logic                 cfg_we,
    input  logic [PW-1:0]        cfg_addr,
    input  logic [att_width-1:0] cfg_bias1,
    input  logic [att_width-1:0] cfg_bias2,
    output logic                 stage_en,
    output logic [att_width-1:0] stage_in,
    output logic [att_width-1:0] stage_bias_1,
    output logic [att_width-1:0] stage_bias_2,
    input  logic                 stage_end,
    input  logic [att_width-1:0] stage_out,
    output logic [PW-1:0]        pass_idx,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] LAST_PASS = PW'(N_PASS - 1);
    localparam logic [CW-1:0] CNT_MAX   = CW'(TIMEOUT);

    seq_state_t           state_q, state_d;
    logic [att_width-1:0] work_q, work_d;
    logic [att_width-1:0] bias1_q, bias1_d, bias2_q, bias2_d;
    logic [PW-1:0]        pass_q, pass_d;
    logic [CW-1:0]        cnt_q, cnt_d, cnt_inc_s;
    logic                 err_q, err_d;
    logic                 in_ready_q, stage_en_q, out_valid_q, busy_q;
    logic [att_width-1:0] stage_in_q, sbias1_q, sbias2_q, out_data_q;
    logic [PW-1:0]        rd_addr_s;
    logic [att_width-1:0] tbl_b1_s, tbl_b2_s, snap_b1_s, snap_b2_s;

    stage_bias_table #(.N_PASS(N_PASS), .AW(PW)) u_table (
        .clk      (clk),
        .rstn     (rstn),
        .we_i     (cfg_we),
        .waddr_i  (cfg_addr),
        .wbias1_i (cfg_bias1),
        .wbias2_i (cfg_bias2),
        .raddr_i  (rd_addr_s),
        .rbias1_o (tbl_b1_s),
        .rbias2_o (tbl_b2_s)
    );

    // A write landing on the snapshot edge itself is forwarded so it is not missed.
    assign rd_addr_s = (state_q == SEQ_RUN) ? pass_q + PW'(1) : '0;
    assign snap_b1_s = (cfg_we && (cfg_addr == rd_addr_s)) ? cfg_bias1 : tbl_b1_s;
    assign snap_b2_s = (cfg_we && (cfg_addr == rd_addr_s)) ? cfg_bias2 : tbl_b2_s;
    assign cnt_inc_s = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

    // Next-state logic; stage_end has priority over the timeout.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        pass_d  = pass_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        bias1_d = bias1_q;
        bias2_d = bias2_q;
        case (state_q)
            SEQ_IDLE: begin
                if (in_valid && in_ready_q) begin
                    work_d  = in_data;
                    pass_d  = '0;
                    cnt_d   = '0;
                    bias1_d = snap_b1_s;
                    bias2_d = snap_b2_s;
                    state_d = SEQ_RUN;
                end else begin
                    state_d = SEQ_IDLE;
                end
            end
            SEQ_RUN: begin
                cnt_d = cnt_inc_s;
                if (stage_end) begin
                    work_d = stage_out;
                    if (pass_q == LAST_PASS) begin
                        state_d = SEQ_OUT;
                    end else begin
                        pass_d  = pass_q + PW'(1);
                        bias1_d = snap_b1_s;
                        bias2_d = snap_b2_s;
                        state_d = SEQ_GAP;
                    end
                end else if (cnt_inc_s == CNT_MAX) begin
                    err_d   = 1'b1;
                    state_d = SEQ_OUT;
                end else begin
                    state_d = SEQ_RUN;
                end
            end
            SEQ_GAP: begin
                cnt_d   = '0;
                state_d = SEQ_RUN;
            end
            SEQ_OUT: begin
                if (out_ready) begin
                    state_d = SEQ_IDLE;
                end else begin
                    state_d = SEQ_OUT;
                end
            end
            default: state_d = SEQ_IDLE;
        endcase
    end

    // State, datapath registers and outputs registered from the next state.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= SEQ_IDLE;
            work_q      <= '0;
            pass_q      <= '0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
            bias1_q     <= '0;
            bias2_q     <= '0;
            in_ready_q  <= 1'b0;
            stage_en_q  <= 1'b0;
            stage_in_q  <= '0;
            sbias1_q    <= '0;
            sbias2_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            pass_q      <= pass_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            bias1_q     <= bias1_d;
            bias2_q     <= bias2_d;
            in_ready_q  <= (state_d == SEQ_IDLE);
            stage_en_q  <= (state_d == SEQ_RUN);
            stage_in_q  <= (state_d == SEQ_RUN) ? work_d  : '0;
            sbias1_q    <= (state_d == SEQ_RUN) ? bias1_d : '0;
            sbias2_q    <= (state_d == SEQ_RUN) ? bias2_d : '0;
            out_valid_q <= (state_d == SEQ_OUT);
            out_data_q  <= (state_d == SEQ_OUT) ? work_d  : '0;
            busy_q      <= (state_d != SEQ_IDLE);
        end
    end

    assign in_ready     = in_ready_q;
    assign stage_en     = stage_en_q;
    assign stage_in     = stage_in_q;
    assign stage_bias_1 = sbias1_q;
    assign stage_bias_2 = sbias2_q;
    assign out_valid    = out_valid_q;
    assign out_data     = out_data_q;
    assign pass_idx     = pass_q;
    assign busy         = busy_q;
    assign err_timeout  = err_q;
endmodule

// File: tb/tb_stage_seq_ctrl.sv
// Scoreboard bench for stage_seq_ctrl with a behavioural stage of configurable latency.
module tb_stage_seq_ctrl;
    localparam int N  = 4;
    localparam int TO = 8;
    localparam int W  = 16;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0, in_ready;
    logic [W-1:0] in_data = '0;
    logic         out_valid, out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         cfg_we = 1'b0;
    logic [1:0]   cfg_addr = '0;
    logic [W-1:0] cfg_bias1 = '0, cfg_bias2 = '0;
    logic         stage_en, stage_end, busy, err_timeout;
    logic [W-1:0] stage_in, stage_bias_1, stage_bias_2, stage_out;
    logic [1:0]   pass_idx;

    int checks = 0;
    int errors = 0;
    int lat = 3;
    int scnt;
    logic [W-1:0] mb1 [N];
    logic [W-1:0] mb2 [N];
    logic [W-1:0] exp_b1_q[$], exp_b2_q[$], exp_out_q[$];

    stage_seq_ctrl #(.N_PASS(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_bias1(cfg_bias1), .cfg_bias2(cfg_bias2),
        .stage_en(stage_en), .stage_in(stage_in), .stage_bias_1(stage_bias_1),
        .stage_bias_2(stage_bias_2), .stage_end(stage_end), .stage_out(stage_out),
        .pass_idx(pass_idx), .busy(busy), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Stage model: end flag in the lat-th enabled cycle (lat==0: never).
    always @(posedge clk or negedge rstn) begin
        if (!rstn)          scnt <= 0;
        else if (!stage_en) scnt <= 0;
        else                scnt <= scnt + 1;
    end
    assign stage_end = stage_en && (lat > 0) && (scnt == lat - 1);
    assign stage_out = stage_in + stage_bias_1;

    task automatic cfg_write(input int a, input logic [W-1:0] b1, input logic [W-1:0] b2);
        @(negedge clk);
        cfg_we = 1'b1; cfg_addr = 2'(a); cfg_bias1 = b1; cfg_bias2 = b2;
        mb1[a] = b1; mb2[a] = b2;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load_table();
        for (int i = 0; i < N; i++) cfg_write(i, W'(i + 1), W'(2 * i));
    endtask

    task automatic send_token(input logic [W-1:0] tok);
        int g;
        g = 0;
        @(negedge clk);
        in_valid = 1'b1; in_data = tok;
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Runs one token end to end, checking per-pass biases, latency and result.
    task automatic run_token(input logic [W-1:0] tok, input int lat_i, input bit cfg_mid,
                             input int hold, input logic exp_err, input bit exp_to);
        logic [W-1:0] res, cur_b1, cur_b2, got;
        int k, pass_n, exp_lat;
        bit prev_en, done;
        lat = lat_i;
        res = tok;
        exp_b1_q.push_back(mb1[0]); exp_b2_q.push_back(mb2[0]);
        if (!exp_to) res = res + mb1[0];
        if (cfg_mid) begin
            mb1[1] = 16'd100; mb2[1] = 16'd77;
            mb1[0] = 16'd50;  mb2[0] = 16'd55;
        end
        if (!exp_to) begin
            for (int i = 1; i < N; i++) begin
                exp_b1_q.push_back(mb1[i]); exp_b2_q.push_back(mb2[i]);
                res = res + mb1[i];
            end
        end
        exp_out_q.push_back(res);
        exp_lat = exp_to ? TO + 1 : N * lat_i + N;
        cur_b1 = '0; cur_b2 = '0;
        send_token(tok);
        k = 0; pass_n = 0; prev_en = 1'b0; done = 1'b0;
        while (!done && k < 400) begin
            @(negedge clk);
            k++;
            if (cfg_mid && k == 1) begin
                cfg_we = 1'b1; cfg_addr = 2'd1; cfg_bias1 = 16'd100; cfg_bias2 = 16'd77;
            end else if (cfg_mid && k == 2) begin
                cfg_we = 1'b1; cfg_addr = 2'd0; cfg_bias1 = 16'd50; cfg_bias2 = 16'd55;
            end else begin
                cfg_we = 1'b0;
            end
            if (stage_en && !prev_en) begin
                checks++;
                if (exp_b1_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_pass: pass %0d started, none expected", pass_n);
                end else begin
                    cur_b1 = exp_b1_q.pop_front(); cur_b2 = exp_b2_q.pop_front();
                end
                checks++;
                if (pass_idx !== 2'(pass_n)) begin
                    errors++;
                    $display("FAIL pass_idx: got %0d required %0d", pass_idx, pass_n);
                end
                pass_n++;
            end
            if (stage_en) begin
                checks++;
                if (stage_bias_1 !== cur_b1 || stage_bias_2 !== cur_b2) begin
                    errors++;
                    $display("FAIL bias_p%0d: got %0d/%0d required %0d/%0d", pass_n - 1,
                             stage_bias_1, stage_bias_2, cur_b1, cur_b2);
                end
            end else if (stage_in !== '0 || stage_bias_1 !== '0 || stage_bias_2 !== '0) begin
                checks++;
                errors++;
                $display("FAIL idle_zero: stage_in=%0d b1=%0d b2=%0d required 0",
                         stage_in, stage_bias_1, stage_bias_2);
            end
            prev_en = stage_en;
            if (out_valid) begin
                done = 1'b1;
                got = exp_out_q.pop_front();
                checks++;
                if (k != exp_lat) begin
                    errors++;
                    $display("FAIL latency: got %0d required %0d", k, exp_lat);
                end
                checks++;
                if (out_data !== got) begin
                    errors++;
                    $display("FAIL out_data: got %0d required %0d", out_data, got);
                end
                checks++;
                if (err_timeout !== exp_err) begin
                    errors++;
                    $display("FAIL err_timeout: got %b required %b", err_timeout, exp_err);
                end
                for (int h = 0; h < hold; h++) begin
                    @(negedge clk);
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== got || in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL hold%0d: ov=%b data=%0d ir=%b required 1/%0d/0",
                                 h, out_valid, out_data, in_ready, got);
                    end
                end
                out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
                @(negedge clk);
                checks++;
                if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
                    errors++;
                    $display("FAIL release: ov=%b ir=%b busy=%b required 0/1/0",
                             out_valid, in_ready, busy);
                end
            end
        end
        cfg_we = 1'b0;
        checks++;
        if (!done || exp_b1_q.size() != 0) begin
            errors++;
            $display("FAIL token_end: done=%b passes_left=%0d required 1/0", done, exp_b1_q.size());
            exp_b1_q.delete(); exp_b2_q.delete(); exp_out_q.delete();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, out_data, stage_en, stage_in, stage_bias_1, stage_bias_2,
             pass_idx, busy, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: some output nonzero (ir=%b en=%b busy=%b)",
                     in_ready, stage_en, busy);
        end
        rstn = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_early: got %b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ready_rise: got %b required 1", in_ready);
        end
        for (int i = 0; i < N; i++) begin
            mb1[i] = '0; mb2[i] = '0;
        end
        load_table();
    endtask

    task automatic test_main();
        run_token(16'd10, 3, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_token(16'd3, 3, 1'b0, 5, 1'b0, 1'b0);
    endtask

    task automatic test_cfg_mid();
        run_token(16'd20, 3, 1'b1, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout_edge();
        run_token(16'd5, TO, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_token(16'h1234, 0, 1'b0, 0, 1'b1, 1'b1);
        run_token(16'd7, 3, 1'b0, 1, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int g;
        lat = 3;
        send_token(16'd40);
        g = 0;
        while (!(stage_en && pass_idx == 2'd2) && g < 100) begin
            @(negedge clk);
            g++;
        end
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, stage_en, stage_in, stage_bias_1, stage_bias_2,
             pass_idx, busy, err_timeout} !== '0) begin
            errors++;
            $display("FAIL reset_mid: en=%b pidx=%0d busy=%b err=%b required all 0",
                     stage_en, pass_idx, busy, err_timeout);
        end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < N; i++) begin
            mb1[i] = '0; mb2[i] = '0;
        end
        run_token(16'd9, 3, 1'b0, 0, 1'b0, 1'b0);
        load_table();
        run_token(16'd10, 3, 1'b0, 0, 1'b0, 1'b0);
    endtask

    initial begin
        test_reset();
        test_main();
        test_backpressure();
        test_cfg_mid();
        test_timeout_edge();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
